// File: rtl/cpu_pkg.sv
// Shared CPU definitions: ALU op encodings and default datapath sizes.
package cpu_pkg;

  localparam int DEFAULT_DATA_W = 32;
  localparam int DEFAULT_REG_N  = 32;

  // ALU op encodings; 3'b110 and 3'b111 are carried through untouched
  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_NOR = 3'b101;

endpackage

// File: rtl/operand_stage_if.sv
// Issue-side bundle: instruction handshake, writeback strobe and ALU operand handshake.
interface operand_stage_if
  import cpu_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int RA_W   = $clog2(DEFAULT_REG_N)
);

  logic              in_valid;
  logic              in_ready;
  logic [2:0]        in_op;
  logic [RA_W-1:0]   in_rs1;
  logic [RA_W-1:0]   in_rs2;
  logic [RA_W-1:0]   in_rd;
  logic              in_use_imm;
  logic [DATA_W-1:0] in_imm;

  logic              wb_en;
  logic [RA_W-1:0]   wb_rd;
  logic [DATA_W-1:0] wb_data;

  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_a;
  logic [DATA_W-1:0] out_b;
  logic [2:0]        out_op;
  logic [RA_W-1:0]   out_rd;

  // Driver side: front end, writeback source and ALU consumer
  modport master (
    output in_valid, in_op, in_rs1, in_rs2, in_rd, in_use_imm, in_imm,
    output wb_en, wb_rd, wb_data, out_ready,
    input  in_ready, out_valid, out_a, out_b, out_op, out_rd
  );

  // The operand stage itself
  modport slave (
    input  in_valid, in_op, in_rs1, in_rs2, in_rd, in_use_imm, in_imm,
    input  wb_en, wb_rd, wb_data, out_ready,
    output in_ready, out_valid, out_a, out_b, out_op, out_rd
  );

endinterface

// File: rtl/regfile.sv
// Architectural register file: two combinational read ports, one write port, r0 fixed at zero.
module regfile
  import cpu_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int REG_N  = DEFAULT_REG_N,
  localparam int RA_W  = $clog2(REG_N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [RA_W-1:0]   ra1,
  input  logic [RA_W-1:0]   ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  input  logic              we,
  input  logic [RA_W-1:0]   wa,
  input  logic [DATA_W-1:0] wd
);

  logic [DATA_W-1:0] regs [REG_N];

  // Reset clears every entry; writes to r0 are dropped and writes during reset are ignored
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_N; i++) begin
        regs[i] <= '0;
      end
    end else if (we && (wa != '0)) begin
      regs[wa] <= wd;
    end
  end

  // r0 is forced to zero on the read side so it never depends on storage contents
  assign rd1 = (ra1 == '0) ? '0 : regs[ra1];
  assign rd2 = (ra2 == '0) ? '0 : regs[ra2];

endmodule

// File: rtl/operand_stage.sv
// Issue stage ahead of the ALU: operand read with writeback bypass, RAW scoreboard,
// and a registered valid/ready output carrying a, b, op and the destination tag.
module operand_stage
  import cpu_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int REG_N  = DEFAULT_REG_N
) (
  input logic           clk,
  input logic           rst,
  operand_stage_if.slave bus
);

  localparam int RA_W = $clog2(REG_N);

  logic [DATA_W-1:0] rf_rd1;
  logic [DATA_W-1:0] rf_rd2;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] rs2_val;
  logic [DATA_W-1:0] op_b;
  logic              fwd1;
  logic              fwd2;
  logic              hazard;
  logic              accept;

  logic [REG_N-1:0]  pend_reg;
  logic [REG_N-1:0]  pend_next;

  logic              out_valid_reg;
  logic [DATA_W-1:0] out_a_reg;
  logic [DATA_W-1:0] out_b_reg;
  logic [2:0]        out_op_reg;
  logic [RA_W-1:0]   out_rd_reg;

  regfile #(
    .DATA_W (DATA_W),
    .REG_N  (REG_N)
  ) u_regfile (
    .clk (clk),
    .rst (rst),
    .ra1 (bus.in_rs1),
    .ra2 (bus.in_rs2),
    .rd1 (rf_rd1),
    .rd2 (rf_rd2),
    .we  (bus.wb_en),
    .wa  (bus.wb_rd),
    .wd  (bus.wb_data)
  );

  // A same-cycle writeback to a source register overrides the not-yet-updated file value
  assign fwd1    = bus.wb_en && (bus.wb_rd == bus.in_rs1) && (bus.in_rs1 != '0);
  assign fwd2    = bus.wb_en && (bus.wb_rd == bus.in_rs2) && (bus.in_rs2 != '0);
  assign op_a    = fwd1 ? bus.wb_data : rf_rd1;
  assign rs2_val = fwd2 ? bus.wb_data : rf_rd2;
  assign op_b    = bus.in_use_imm ? bus.in_imm : rs2_val;

  // A pending source stalls unless its producer is writing back right now (bypass covers it)
  assign hazard = (pend_reg[bus.in_rs1] && !(bus.wb_en && (bus.wb_rd == bus.in_rs1))) ||
                  (!bus.in_use_imm && pend_reg[bus.in_rs2] &&
                   !(bus.wb_en && (bus.wb_rd == bus.in_rs2)));

  assign bus.in_ready = !hazard && (!out_valid_reg || bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;

  // Per-register pending update: a new owner's set beats a retiring writeback's clear
  assign pend_next[0] = 1'b0;
  for (genvar gi = 1; gi < REG_N; gi++) begin : g_pend
    assign pend_next[gi] = (accept && (bus.in_rd == RA_W'(gi))) ||
                           (pend_reg[gi] && !(bus.wb_en && (bus.wb_rd == RA_W'(gi))));
  end

  // Scoreboard state
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_reg <= '0;
    end else begin
      pend_reg <= pend_next;
    end
  end

  // Output register: load on accept, drop valid once consumed, hold while stalled
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_reg <= 1'b0;
      out_a_reg     <= '0;
      out_b_reg     <= '0;
      out_op_reg    <= '0;
      out_rd_reg    <= '0;
    end else if (accept) begin
      out_valid_reg <= 1'b1;
      out_a_reg     <= op_a;
      out_b_reg     <= op_b;
      out_op_reg    <= bus.in_op;
      out_rd_reg    <= bus.in_rd;
    end else if (bus.out_ready) begin
      out_valid_reg <= 1'b0;
    end
  end

  assign bus.out_valid = out_valid_reg;
  assign bus.out_a     = out_a_reg;
  assign bus.out_b     = out_b_reg;
  assign bus.out_op    = out_op_reg;
  assign bus.out_rd    = out_rd_reg;

endmodule

// File: tb/tb_operand_stage.sv
// Bench for operand_stage: directed scenarios followed by randomized traffic,
// all checked against a transaction-level model of registers, pending bits and outputs.
module tb_operand_stage;
  import cpu_pkg::*;

  localparam int DW = 32;
  localparam int RN = 32;
  localparam int RW = $clog2(RN);

  typedef struct packed {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [2:0]    op;
    logic [RW-1:0] rd;
  } txn_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  operand_stage_if #(.DATA_W(DW), .RA_W(RW)) bus ();

  operand_stage #(.DATA_W(DW), .REG_N(RN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks_total = 0;
  int checks_pass  = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks_total++;
    if (got === exp) checks_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  // ---------------- reference model ----------------
  logic [DW-1:0] model_regs [RN];
  bit            model_pend [RN];
  txn_t          exp_q [$];
  txn_t          mt;
  bit            m_haz;
  bit            m_rdy;

  function automatic logic [DW-1:0] model_read(input logic [RW-1:0] idx);
    if (idx == 0) return '0;
    if (bus.wb_en && bus.wb_rd == idx) return bus.wb_data;
    return model_regs[idx];
  endfunction

  // Observe one cycle, then advance the model to what the coming edge should produce
  always @(negedge clk) begin
    if (rst) begin
      for (int i = 0; i < RN; i++) begin
        model_regs[i] = '0;
        model_pend[i] = 1'b0;
      end
      exp_q.delete();
    end else begin
      check_eq("out_valid", 64'(bus.out_valid), 64'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
        check_eq("out_a",  64'(bus.out_a),  64'(exp_q[0].a));
        check_eq("out_b",  64'(bus.out_b),  64'(exp_q[0].b));
        check_eq("out_op", 64'(bus.out_op), 64'(exp_q[0].op));
        check_eq("out_rd", 64'(bus.out_rd), 64'(exp_q[0].rd));
      end
      m_haz = (model_pend[bus.in_rs1] && !(bus.wb_en && bus.wb_rd == bus.in_rs1)) ||
              (!bus.in_use_imm && model_pend[bus.in_rs2] &&
               !(bus.wb_en && bus.wb_rd == bus.in_rs2));
      m_rdy = !m_haz && (exp_q.size() == 0 || bus.out_ready);
      check_eq("in_ready", 64'(bus.in_ready), 64'(m_rdy));

      mt.a  = model_read(bus.in_rs1);
      mt.b  = bus.in_use_imm ? bus.in_imm : model_read(bus.in_rs2);
      mt.op = bus.in_op;
      mt.rd = bus.in_rd;
      if (exp_q.size() != 0 && bus.out_ready) void'(exp_q.pop_front());
      if (bus.in_valid && m_rdy) exp_q.push_back(mt);
      if (bus.wb_en) begin
        if (bus.wb_rd != 0) model_regs[bus.wb_rd] = bus.wb_data;
        model_pend[bus.wb_rd] = 1'b0;
      end
      if (bus.in_valid && m_rdy && bus.in_rd != 0) model_pend[bus.in_rd] = 1'b1;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.in_valid   = 1'b0;
    bus.in_op      = '0;
    bus.in_rs1     = '0;
    bus.in_rs2     = '0;
    bus.in_rd      = '0;
    bus.in_use_imm = 1'b0;
    bus.in_imm     = '0;
    bus.wb_en      = 1'b0;
    bus.wb_rd      = '0;
    bus.wb_data    = '0;
  endtask

  task automatic issue(input logic [2:0] op, input int rs1, input int rs2, input int rd,
                       input logic use_imm, input logic [DW-1:0] imm);
    bus.in_valid   = 1'b1;
    bus.in_op      = op;
    bus.in_rs1     = RW'(rs1);
    bus.in_rs2     = RW'(rs2);
    bus.in_rd      = RW'(rd);
    bus.in_use_imm = use_imm;
    bus.in_imm     = imm;
  endtask

  task automatic writeback(input int rd, input logic [DW-1:0] data);
    bus.wb_en   = 1'b1;
    bus.wb_rd   = RW'(rd);
    bus.wb_data = data;
  endtask

  initial begin
    idle();
    bus.out_ready = 1'b1;

    // Reset with a writeback presented: it must not land
    rst = 1'b1;
    writeback(5, 32'hFFFF_FFFF);
    repeat (2) tick();
    rst = 1'b0;
    idle();
    issue(OP_ADD, 5, 0, 0, 1'b0, '0);
    @(negedge clk) check_eq("rst_in_ready", 64'(bus.in_ready), 64'd1);
    tick(); idle();
    @(negedge clk);
    check_eq("rst_out_valid", 64'(bus.out_valid), 64'd1);
    check_eq("rst_out_a", 64'(bus.out_a), 64'd0);
    check_eq("rst_out_b", 64'(bus.out_b), 64'd0);

    // Basic issue
    tick(); writeback(1, 32'hA5A5_A5A5);
    tick(); writeback(2, 32'h5A5A_5A5A);
    tick(); idle(); issue(OP_SUB, 1, 2, 3, 1'b0, '0);
    tick(); idle();
    @(negedge clk);
    check_eq("basic_a", 64'(bus.out_a), 64'hA5A5_A5A5);
    check_eq("basic_b", 64'(bus.out_b), 64'h5A5A_5A5A);
    check_eq("basic_op", 64'(bus.out_op), 64'(OP_SUB));
    check_eq("basic_rd", 64'(bus.out_rd), 64'd3);

    // Stall on r4, then accept in the writeback cycle via bypass
    tick(); issue(OP_ADD, 0, 0, 4, 1'b0, '0);
    tick(); issue(OP_AND, 4, 0, 7, 1'b0, '0);
    @(negedge clk) check_eq("stall_ready0", 64'(bus.in_ready), 64'd0);
    tick();
    @(negedge clk) check_eq("stall_ready1", 64'(bus.in_ready), 64'd0);
    tick(); writeback(4, 32'h1234_5678);
    @(negedge clk) check_eq("bypass_ready", 64'(bus.in_ready), 64'd1);
    tick(); idle();
    @(negedge clk) check_eq("bypass_a", 64'(bus.out_a), 64'h1234_5678);
    tick();

    // Backpressure: held output, blocked input, nothing lost or duplicated
    bus.out_ready = 1'b0;
    issue(OP_OR, 1, 2, 0, 1'b0, '0);
    @(negedge clk) check_eq("bp_first_ready", 64'(bus.in_ready), 64'd1);
    tick(); issue(OP_XOR, 2, 1, 0, 1'b0, '0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("bp_in_ready", 64'(bus.in_ready), 64'd0);
      check_eq("bp_hold_a", 64'(bus.out_a), 64'hA5A5_A5A5);
      check_eq("bp_hold_op", 64'(bus.out_op), 64'(OP_OR));
      tick();
    end
    bus.out_ready = 1'b1;
    @(negedge clk) check_eq("bp_release_ready", 64'(bus.in_ready), 64'd1);
    tick(); idle();
    @(negedge clk);
    check_eq("bp_next_a", 64'(bus.out_a), 64'h5A5A_5A5A);
    check_eq("bp_next_op", 64'(bus.out_op), 64'(OP_XOR));
    tick();

    // r0 write ignored, immediate bypasses a pending rs2, rd=0 sets nothing
    issue(OP_ADD, 0, 0, 2, 1'b0, '0);
    tick(); idle(); writeback(0, 32'd7);
    tick(); idle(); issue(OP_ADD, 0, 2, 0, 1'b1, 32'h5A5A_5A5A);
    @(negedge clk) check_eq("imm_ready", 64'(bus.in_ready), 64'd1);
    tick(); issue(OP_ADD, 0, 0, 0, 1'b0, '0);
    @(negedge clk);
    check_eq("imm_a", 64'(bus.out_a), 64'd0);
    check_eq("imm_b", 64'(bus.out_b), 64'h5A5A_5A5A);
    check_eq("r0_not_pending", 64'(bus.in_ready), 64'd1);
    tick(); idle(); writeback(2, 32'h5A5A_5A5A);
    tick(); idle();

    // Set/clear collision on r6: the new owner keeps it pending
    issue(OP_ADD, 0, 0, 6, 1'b0, '0);
    writeback(6, 32'h0000_0066);
    tick(); idle(); issue(OP_ADD, 6, 0, 0, 1'b0, '0);
    @(negedge clk) check_eq("coll_stall0", 64'(bus.in_ready), 64'd0);
    tick();
    @(negedge clk) check_eq("coll_stall1", 64'(bus.in_ready), 64'd0);
    tick(); writeback(6, 32'h0000_600D);
    @(negedge clk) check_eq("coll_release", 64'(bus.in_ready), 64'd1);
    tick(); idle();
    @(negedge clk) check_eq("coll_a", 64'(bus.out_a), 64'h0000_600D);
    tick();

    // Randomized traffic with occasional mid-run resets
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 299) == 0);
      bus.in_valid   = ($urandom_range(0, 3) != 0);
      bus.in_op      = 3'($urandom_range(0, 7));
      bus.in_rs1     = RW'($urandom_range(0, 7));
      bus.in_rs2     = RW'($urandom_range(0, 7));
      bus.in_rd      = RW'($urandom_range(0, 7));
      bus.in_use_imm = ($urandom_range(0, 3) == 0);
      bus.in_imm     = $urandom();
      bus.wb_en      = ($urandom_range(0, 9) < 4);
      bus.wb_rd      = RW'($urandom_range(0, 7));
      bus.wb_data    = $urandom();
      bus.out_ready  = ($urandom_range(0, 4) != 0);
      tick();
    end

    // Drain and confirm the output empties
    rst = 1'b0;
    idle();
    bus.out_ready = 1'b1;
    repeat (3) tick();
    @(negedge clk) check_eq("drain_empty", 64'(bus.out_valid), 64'd0);

    $display("%0d/%0d checks passed", checks_pass, checks_total);
    $finish;
  end

endmodule

// File: doc/operand_stage.md
# operand_stage

Issue stage directly upstream of the ALU. It holds the 32-entry register file, reads and bypasses the two source operands, tracks outstanding destination registers with a scoreboard to stall on read-after-write hazards, and presents `a`, `b`, `op` and the destination tag to the ALU through a registered valid/ready output. ALU results return through the writeback port.

## Interface
- `DATA_W`, 32: operand and register width; matches the ALU `a`, `b` and `result` width.
- `REG_N`, 32: number of architectural registers. Register index width `RA_W = $clog2(REG_N)`.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: an instruction is offered.
- `in_ready` out 1: the stage accepts the instruction this cycle.
- `in_op` in 3: ALU op (000 add, 001 sub, 010 and, 011 or, 100 xor, 101 nor). Codes 110 and 111 pass through unchanged.
- `in_rs1`, `in_rs2` in RA_W: source register indices.
- `in_rd` in RA_W: destination index. 0 means no writeback.
- `in_use_imm` in 1: `b` is taken from `in_imm` instead of `rs2`.
- `in_imm` in DATA_W: immediate value.
- `wb_en` in 1: writeback strobe.
- `wb_rd` in RA_W: writeback index.
- `wb_data` in DATA_W: writeback value.
- `out_valid` out 1: ALU operands are valid.
- `out_ready` in 1: the ALU side accepts the operands.
- `out_a`, `out_b` out DATA_W: operands to the ALU.
- `out_op` out 3: op to the ALU.
- `out_rd` out RA_W: destination tag travelling with the op.

## Operation
- **Register file**
  - `r0` reads as 0 and ignores writes.
  - A write with `wb_en` and `wb_rd != 0` commits at the clock edge.
- **Bypass**
  - If a source register equals `wb_rd` in the same cycle (with `wb_en` set and `rs != 0`), the operand is `wb_data`, not the stale file value.
- **Scoreboard**
  - One pending bit per register.
  - Set on accept when `in_rd != 0`.
  - Cleared on `wb_en` for `wb_rd`.
  - If the same register is set and cleared in the same cycle, set wins, because the newer instruction still owns it.
- **Hazard**
  - `hazard = (pend[rs1] && !(wb_en && wb_rd == rs1)) || (!in_use_imm && pend[rs2] && !(wb_en && wb_rd == rs2))`.
  - `pend[0]` is always 0.
- **Handshake**
  - `in_ready = !hazard && (!out_valid || out_ready)`.
  - Accept occurs when `in_valid && in_ready`.
  - `in_ready` may depend on the `in_*` fields.
- **Output register**
  - On accept, load `out_a`, `out_b`, `out_op`, `out_rd` and set `out_valid`.
  - Else if `out_ready`, clear `out_valid`.
  - While `out_valid && !out_ready`, all `out_*` signals hold stable.
- **Reset**
  - All registers are cleared to 0.
  - All pending bits are cleared.
  - `out_valid=0`, and `out_a`, `out_b`, `out_op`, `out_rd` are 0.
  - `in_ready` is 1 in the first cycle after reset.
- **Reset mid-operation**
  - Any in-flight output is discarded.
  - Writebacks presented during reset are ignored.

## Timing
- Latency: accept at edge N, `out_valid` is high after edge N.
- Throughput is 1 per cycle when there are no hazards and `out_ready=1`.
- A dependent instruction stalls until the cycle its producer's `wb_en` is asserted. It is accepted in that same cycle using the bypassed `wb_data`, so there is no extra bubble after writeback.
- Writeback commits and the scoreboard clear at the same edge as an accept.
- There are no combinational paths from `out_ready` to `out_*` data. `out_ready` affects `in_ready` combinationally.

## Structure
- Shared package `cpu_pkg` holds:
  - the ALU op localparams `OP_ADD`..`OP_NOR`, shared with the ALU;
  - `DATA_W` and `REG_N` defaults.
- Sub-module `regfile`: 2 asynchronous read ports, 1 synchronous write port, `r0` hardwired, synchronous reset.
- Bypass, scoreboard and output register live in the `operand_stage` top.

## Test plan
- **Reset.** Assert `rst` for 2 cycles with `wb_en=1`, `wb_rd=5`, `wb_data=0xFFFFFFFF`. Then issue `rs1=5`, `rs2=0`, `op=000`. Expect `out_a=0`, `out_b=0`, `out_valid=1` one cycle after accept.
- **Basic issue.** Writeback `r1=0xA5A5A5A5` and `r2=0x5A5A5A5A`. Issue `op=001`, `rs1=1`, `rs2=2`, `rd=3`. Expect `out_a=0xA5A5A5A5`, `out_b=0x5A5A5A5A`, `out_op=001`, `out_rd=3`.
- **Stall and bypass.** Issue with `rd=4`. Next, issue with `rs1=4`. Expect `in_ready=0` until `wb_en`, `wb_rd=4`, `wb_data=0x12345678`. In that cycle expect `in_ready=1`, then `out_a=0x12345678`.
- **Backpressure.** Hold `out_ready=0` for 3 cycles with `in_valid=1`. Expect `out_*` stable, `in_ready=0`, and no instruction lost or duplicated once `out_ready=1`.
- **r0 and immediate.** Writeback `wb_rd=0`, `wb_data=7`. Then issue `rs1=0`, `in_use_imm=1`, `imm=0x5A5A5A5A`, `rd=0` with `r2` pending. Expect no stall, `out_a=0`, `out_b=0x5A5A5A5A`, and no scoreboard bit set.
- **Set/clear collision.** In one cycle, writeback `r6` while accepting a new `rd=6`. Expect `pend[6]=1` afterwards: a following read of `r6` stalls until the next `wb_rd=6`.
